// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the RAM region base.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [31:0] RAM_BASE_ADDR = 32'h1000_3000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  logic [PTR_W:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr + i never exceeds 2*NUM_REQ-2, so one conditional subtract wraps it
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!any && req[idx[PTR_W-1:0]]) begin
        any       = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS sequencing,
// response return and ACCESS-phase timeout. All outputs are registered.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            rsp_err,
  output logic [ADDR_W-1:0]               PADDR,
  output logic                            PWRITE,
  output logic [DATA_W-1:0]               PWDATA,
  output logic                            PSEL,
  output logic                            PENABLE,
  input  logic [DATA_W-1:0]               PRDATA,
  input  logic                            PREADY
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  apb_state_e          state, state_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]    owner, owner_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic [NUM_REQ-1:0]  req_ready_n, rsp_valid_n;
  logic [DATA_W-1:0]   rsp_rdata_n, pwdata_n;
  logic                rsp_err_n, pwrite_n, psel_n, penable_n;
  logic [ADDR_W-1:0]   paddr_n;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      PADDR     <= paddr_n;
      PWRITE    <= pwrite_n;
      PWDATA    <= pwdata_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    cnt_n       = cnt;
    req_ready_n = '0;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    paddr_n     = PADDR;
    pwrite_n    = PWRITE;
    pwdata_n    = PWDATA;
    psel_n      = PSEL;
    penable_n   = PENABLE;

    unique case (state)
      IDLE: begin
        if (grant_any) begin
          paddr_n     = req_addr[grant_idx];
          pwrite_n    = req_write[grant_idx];
          pwdata_n    = req_wdata[grant_idx];
          req_ready_n = grant;
          owner_n     = grant_idx;
          rr_ptr_n    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          psel_n      = 1'b1;
          penable_n   = 1'b0;
          state_n     = SETUP;
        end
      end
      SETUP: begin
        psel_n    = 1'b1;
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing in the same cycle
        if (PREADY) begin
          rsp_valid_n        = '0;
          rsp_valid_n[owner] = 1'b1;
          rsp_err_n          = 1'b0;
          if (!PWRITE) rsp_rdata_n = PRDATA;
          psel_n             = 1'b0;
          penable_n          = 1'b0;
          state_n            = IDLE;
        end else if (TIMEOUT_CYC != 0 && cnt == CNT_LAST) begin
          rsp_valid_n        = '0;
          rsp_valid_n[owner] = 1'b1;
          rsp_err_n          = 1'b1;
          rsp_rdata_n        = '0;
          psel_n             = 1'b0;
          penable_n          = 1'b0;
          state_n            = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a switchable APB slave (RAM, hang, late, always-ready).
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  localparam int M_RAM    = 0;
  localparam int M_HANG   = 1;
  localparam int M_LATE16 = 2;
  localparam int M_FORCE  = 3;

  logic                           PCLK = 1'b0;
  logic                           PRESETn = 1'b0;
  logic [NUM_REQ-1:0]             req_valid = '0;
  logic [NUM_REQ-1:0]             req_write = '0;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_err;
  logic [ADDR_W-1:0]              PADDR;
  logic                           PWRITE;
  logic [DATA_W-1:0]              PWDATA;
  logic                           PSEL;
  logic                           PENABLE;
  logic [DATA_W-1:0]              PRDATA;
  logic                           PREADY;

  int n_cmp = 0;
  int n_fail = 0;
  int mode = M_RAM;
  int rsp_count = 0;
  int acc_cnt = 0;

  logic [31:0] mem [0:63];
  logic        ram_ready = 1'b0;
  logic [31:0] ram_rdata = '0;

  apb_master_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Word-addressed RAM slave: PREADY registered one cycle after PSEL&&PENABLE
  always @(posedge PCLK) begin
    ram_ready <= PSEL && PENABLE;
    if (PSEL && PENABLE) begin
      if (PWRITE) mem[PADDR[7:2]] <= PWDATA;
      ram_rdata <= mem[PADDR[7:2]];
    end
    if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    PREADY = 1'b0;
    PRDATA = 32'h0;
    case (mode)
      M_RAM:    begin PREADY = ram_ready; PRDATA = ram_rdata; end
      M_HANG:   begin PREADY = 1'b0; PRDATA = 32'hBAD0_BAD0; end
      M_LATE16: begin PREADY = PSEL && PENABLE && (acc_cnt == 15); PRDATA = 32'hCAFE_0016; end
      M_FORCE:  begin PREADY = 1'b1; PRDATA = 32'h5A5A_0001; end
      default:  ;
    endcase
  end

  always @(negedge PCLK) if (|rsp_valid) rsp_count++;

  task automatic xfer(input int r, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output bit ok, output logic [1:0] ph0, output logic [1:0] ph1);
    int n;
    ok = 1'b1; lat = 0; rdata = '0; err = 1'b0; ph0 = '0; ph1 = '0;
    req_write[r] = wr; req_addr[r] = addr; req_wdata[r] = data; req_valid[r] = 1'b1;
    n = 0;
    do begin @(posedge PCLK); #1; n++; end while (!req_ready[r] && n < 40);
    req_valid[r] = 1'b0;
    if (!req_ready[r]) begin ok = 1'b0; return; end
    ph0 = {PSEL, PENABLE};
    @(posedge PCLK); #1; lat = 1;
    ph1 = {PSEL, PENABLE};
    while (!rsp_valid[r] && lat < 60) begin @(posedge PCLK); #1; lat++; end
    if (!rsp_valid[r]) ok = 1'b0;
    rdata = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSEL, PENABLE} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rdy=%b rspv=%b rdata=%h err=%b, want all 0",
               PSEL, PENABLE, PADDR, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_single_rw();
    logic [31:0] rd; logic er; int lat; bit ok; logic [1:0] p0, p1;
    mode = M_RAM;
    xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || p0 !== 2'b10 || p1 !== 2'b11 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: ok=%b setup=%b access=%b err=%b, want ok=1 setup=10 access=11 err=0", ok, p0, p1, er);
    end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
    xfer(0, 1'b0, 32'h08, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || p0 !== 2'b10 || p1 !== 2'b11) begin
      n_fail++;
      $display("FAIL single_read: ok=%b rdata=%h err=%b setup=%b access=%b, want ok=1 rdata=deadbeef err=0 setup=10 access=11",
               ok, rd, er, p0, p1);
    end
  endtask

  task automatic test_round_robin();
    int grants[4]; int ng; logic [31:0] rd; logic er; int lat; bit ok; logic [1:0] p0, p1;
    PRESETn = 1'b0; #2; PRESETn = 1'b1;
    @(posedge PCLK); #1;
    mode = M_RAM;
    req_write = 2'b11;
    req_addr[0] = 32'h0C; req_wdata[0] = 32'h22;
    req_addr[1] = 32'h04; req_wdata[1] = 32'h11;
    req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(posedge PCLK); #1;
      if (req_ready[0]) begin grants[ng] = 0; ng++; end
      else if (req_ready[1]) begin grants[ng] = 1; ng++; end
    end
    req_valid = '0;
    n_cmp++;
    if (ng !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 4", ng); end
    for (int g = 0; g < ng; g++) begin
      n_cmp++;
      if (grants[g] !== (g % 2)) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %0d want %0d", g, grants[g], g % 2);
      end
    end
    repeat (6) @(posedge PCLK); #1;
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || rd !== 32'h11 || er !== 1'b0) begin
      n_fail++; $display("FAIL rr_readback_04: ok=%b rdata=%h err=%b, want ok=1 rdata=11 err=0", ok, rd, er);
    end
    xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || rd !== 32'h22 || er !== 1'b0) begin
      n_fail++; $display("FAIL rr_readback_0c: ok=%b rdata=%h err=%b, want ok=1 rdata=22 err=0", ok, rd, er);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat; bit ok; logic [1:0] p0, p1;
    mode = M_HANG;
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL timeout_rsp: ok=%b err=%b rdata=%h, want ok=1 err=1 rdata=0", ok, er, rd);
    end
    n_cmp++;
    if (lat !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d want 17", lat); end
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_psel_drop: got psel/pen=%b want 00", {PSEL, PENABLE});
    end
    mode = M_RAM;
    xfer(0, 1'b0, 32'h08, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL after_timeout_read: ok=%b rdata=%h err=%b, want ok=1 rdata=deadbeef err=0", ok, rd, er);
    end
  endtask

  task automatic test_late_ready();
    logic [31:0] rd; logic er; int lat; bit ok; logic [1:0] p0, p1;
    mode = M_LATE16;
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || er !== 1'b0 || rd !== 32'hCAFE_0016) begin
      n_fail++; $display("FAIL late_ready_rsp: ok=%b err=%b rdata=%h, want ok=1 err=0 rdata=cafe0016", ok, er, rd);
    end
    n_cmp++;
    if (lat !== 17) begin n_fail++; $display("FAIL late_ready_latency: got %0d want 17", lat); end
    mode = M_RAM;
  endtask

  task automatic test_reset_abort();
    int n; int pre;
    mode = M_HANG;
    req_write[0] = 1'b0; req_addr[0] = 32'h40; req_valid[0] = 1'b1;
    n = 0;
    do begin @(posedge PCLK); #1; n++; end while (!req_ready[0] && n < 40);
    req_valid[0] = 1'b0;
    repeat (3) @(posedge PCLK); #1;
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++; $display("FAIL abort_in_access: got psel/pen=%b want 11", {PSEL, PENABLE});
    end
    pre = rsp_count;
    #1 PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, PADDR} !== '0) begin
      n_fail++; $display("FAIL abort_async_drop: got psel=%b pen=%b paddr=%h want 0", PSEL, PENABLE, PADDR);
    end
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;
    repeat (20) @(posedge PCLK); #1;
    n_cmp++;
    if (rsp_count !== pre) begin
      n_fail++; $display("FAIL abort_no_rsp: got %0d rsp pulses want %0d", rsp_count, pre);
    end
    mode = M_RAM;
    req_write = 2'b00;
    req_addr[0] = 32'h08; req_addr[1] = 32'h04;
    req_valid = 2'b11;
    n = 0;
    do begin @(posedge PCLK); #1; n++; end while (req_ready === 2'b00 && n < 40);
    req_valid = '0;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL abort_rrptr_reset: got req_ready=%b want 01", req_ready);
    end
    repeat (8) @(posedge PCLK); #1;
  endtask

  task automatic test_early_pready();
    int pre; logic [31:0] rd; logic er; int lat; bit ok; logic [1:0] p0, p1;
    mode = M_FORCE;
    pre = rsp_count;
    repeat (5) @(posedge PCLK); #1;
    n_cmp++;
    if (rsp_count !== pre || {PSEL, PENABLE} !== 2'b00) begin
      n_fail++; $display("FAIL idle_pready_ignored: got %0d pulses psel/pen=%b want %0d and 00",
                         rsp_count - pre, {PSEL, PENABLE}, 0);
    end
    xfer(0, 1'b0, 32'h30, 32'h0, rd, er, lat, ok, p0, p1);
    n_cmp++;
    if (ok !== 1'b1 || p0 !== 2'b10 || p1 !== 2'b11 || lat !== 2) begin
      n_fail++; $display("FAIL early_pready_phases: ok=%b setup=%b access=%b lat=%0d, want ok=1 setup=10 access=11 lat=2",
                         ok, p0, p1, lat);
    end
    n_cmp++;
    if (rd !== 32'h5A5A_0001 || er !== 1'b0) begin
      n_fail++; $display("FAIL early_pready_data: rdata=%h err=%b want 5a5a0001 and 0", rd, er);
    end
    mode = M_RAM;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_single_rw();
    test_round_robin();
    test_timeout();
    test_late_ready();
    test_reset_abort();
    test_early_pready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
